smem_arbiter: RTL

- Round-robin arbiter sharing one single-port shared-memory SRAM (4096 x 8) among N GPU cores.
- Each core raises a request with a 12-bit address, a write flag and write data, then waits for a one-cycle data-valid pulse.
- Sits between the core array and the SRAM macro.
- The SRAM has 1-cycle synchronous read latency.

---
 rtl/smem_arb_pkg.sv | 16 +
 rtl/smem_arbiter_rr_pick.sv | 33 +++
 rtl/smem_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/smem_arb_pkg.sv
// Shared types and constants for the shared-memory arbiter: FSM state
// encoding, default memory geometry and the core-index width.
package smem_arb_pkg;

    localparam int SMEM_AW  = 12;
    localparam int SMEM_DW  = 8;
    localparam int CORE_IDW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/smem_arbiter_rr_pick.sv
// Rotating priority encoder: returns the first set request bit scanning
// upward from ptr and wrapping modulo N. Tie ptr to 0 for fixed priority.
module rr_pick
    import smem_arb_pkg::*;
#(
    parameter int N = 16
)(
    input  logic [N-1:0]        req,
    input  logic [CORE_IDW-1:0] ptr,
    output logic [CORE_IDW-1:0] winner,
    output logic                any
);

    logic [CORE_IDW:0] w_sum;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        w_sum  = '0;
        for (int i = 0; i < N; i++) begin
            // ptr < N, so ptr + i < 2N and one conditional subtract wraps it
            w_sum = {1'b0, ptr} + (CORE_IDW + 1)'(i);
            if (w_sum >= (CORE_IDW + 1)'(N)) begin
                w_sum = w_sum - (CORE_IDW + 1)'(N);
            end
            if (!any && req[w_sum[CORE_IDW-1:0]]) begin
                winner = w_sum[CORE_IDW-1:0];
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/smem_arbiter.sv
// Round-robin arbiter granting N cores access to one single-port SRAM.
// Define SMEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module smem_arbiter
    import smem_arb_pkg::*;
#(
    parameter int N_CORES = 16,
    parameter int AW      = SMEM_AW,
    parameter int DW      = SMEM_DW
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CORES-1:0]    mem_req,
    input  logic [N_CORES-1:0]    req_we,
    input  logic [N_CORES*AW-1:0] req_addr,
    input  logic [N_CORES*DW-1:0] req_wdata,
    output logic [N_CORES-1:0]    val_data,
    output logic [DW-1:0]         rd_data,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [AW-1:0]         sram_addr,
    output logic [DW-1:0]         sram_wdata,
    input  logic [DW-1:0]         sram_rdata,
    output logic [CORE_IDW-1:0]   grant_id,
    output logic                  busy
);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [CORE_IDW-1:0] r_grant;
    logic [CORE_IDW-1:0] w_ptr;
    logic [CORE_IDW-1:0] w_winner;
    logic                w_any;
    logic                w_take;
    logic                r_we;
    logic [AW-1:0]       r_addr;
    logic [DW-1:0]       r_wdata;
    logic [DW-1:0]       r_rd_data;

    rr_pick #(
        .N      (N_CORES)
    ) u_pick (
        .req    (mem_req),
        .ptr    (w_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

`ifdef SMEM_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [CORE_IDW-1:0] r_rr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (r_state == RESP) begin
            r_rr_ptr <= (r_grant == CORE_IDW'(N_CORES - 1)) ? '0 : r_grant + 1'b1;
        end
    end

    assign w_ptr = r_rr_ptr;
`endif

    assign w_take = (r_state == IDLE) && w_any;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        sram_en     = 1'b0;
        sram_we     = 1'b0;
        sram_addr   = '0;
        sram_wdata  = '0;
        val_data    = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                sram_en     = 1'b1;
                sram_we     = r_we;
                sram_addr   = r_addr;
                sram_wdata  = r_wdata;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                val_data    = N_CORES'(1) << r_grant;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Grant index and load data are visible outputs, so they clear on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_take) begin
                r_grant <= w_winner;
            end
            if ((r_state == WAIT) && !r_we) begin
                r_rd_data <= sram_rdata;
            end
        end
    end

    // Request fields are captured once at grant; later changes are ignored
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_we    <= req_we[w_winner];
            r_addr  <= req_addr[w_winner*AW +: AW];
            r_wdata <= req_wdata[w_winner*DW +: DW];
        end
    end

    assign rd_data  = r_rd_data;
    assign grant_id = r_grant;
    assign busy     = (r_state != IDLE);

endmodule
